uart: RTL and testbench



---
 rtl/uart.sv | 157 +++++++++++++++
 tb/tb_uart.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart.sv
// rtl/uart.sv - full-duplex 8N1 UART with single-byte TX holding path and RX buffer
module uart #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [7:0] din,
    output logic       wr_rdy,
    input  logic       rd_en,
    output logic       rd_rdy,
    output logic [7:0] dout,
    input  logic       rx,
    output logic       tx
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t          tx_state, tx_next;
    logic [CW-1:0]   tx_cnt;
    logic [2:0]      tx_bit;
    logic [7:0]      tx_shift;
    logic            tx_bit_done;

    assign tx_bit_done = (tx_cnt == BIT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) tx_state <= S_IDLE;
        else     tx_state <= tx_next;
    end

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            S_IDLE:  if (wr_en)                        tx_next = S_START;
            S_START: if (tx_bit_done)                  tx_next = S_DATA;
            S_DATA:  if (tx_bit_done && tx_bit == 3'd7) tx_next = S_STOP;
            S_STOP:  if (tx_bit_done)                  tx_next = S_IDLE;
            default:                                   tx_next = S_IDLE;
        endcase
    end

    // din is captured only at acceptance so later changes cannot corrupt the frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_cnt   <= '0;
            tx_bit   <= 3'd0;
            tx_shift <= 8'h00;
        end else if (tx_state == S_IDLE) begin
            tx_cnt <= '0;
            tx_bit <= 3'd0;
            if (wr_en) tx_shift <= din;
        end else if (tx_bit_done) begin
            tx_cnt <= '0;
            if (tx_state == S_DATA) begin
                tx_shift <= {1'b0, tx_shift[7:1]};
                tx_bit   <= tx_bit + 3'd1;
            end
        end else begin
            tx_cnt <= tx_cnt + 1'b1;
        end
    end

    always_comb begin
        wr_rdy = (tx_state == S_IDLE);
        case (tx_state)
            S_START: tx = 1'b0;
            S_DATA:  tx = tx_shift[0];
            default: tx = 1'b1;
        endcase
    end

    logic            rx_meta, rx_sync;
    state_t          rx_state, rx_next;
    logic [CW-1:0]   rx_cnt;
    logic [2:0]      rx_bit;
    logic [7:0]      rx_shift;
    logic            rx_bit_done, rx_mid_start, byte_ok;

    assign rx_bit_done  = (rx_cnt == BIT_LAST);
    assign rx_mid_start = (rx_cnt == HALF_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rx_state <= S_IDLE;
        else     rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            S_IDLE:  if (!rx_sync)                      rx_next = S_START;
            S_START: if (rx_mid_start)                  rx_next = rx_sync ? S_IDLE : S_DATA;
            S_DATA:  if (rx_bit_done && rx_bit == 3'd7) rx_next = S_STOP;
            S_STOP:  if (rx_bit_done)                   rx_next = S_IDLE;
            default:                                    rx_next = S_IDLE;
        endcase
    end

    // After the half-bit start check, every full-bit count lands on a bit center
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_cnt   <= '0;
            rx_bit   <= 3'd0;
            rx_shift <= 8'h00;
        end else begin
            case (rx_state)
                S_IDLE: begin
                    rx_cnt <= '0;
                    rx_bit <= 3'd0;
                end
                S_START: rx_cnt <= rx_mid_start ? '0 : rx_cnt + 1'b1;
                S_DATA: begin
                    if (rx_bit_done) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        rx_bit   <= rx_bit + 3'd1;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: rx_cnt <= rx_bit_done ? '0 : rx_cnt + 1'b1;
            endcase
        end
    end

    always_comb begin
        byte_ok = (rx_state == S_STOP) && rx_bit_done && rx_sync;
    end

    // A byte completing on the same edge as a pop takes priority and keeps rd_rdy set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout   <= 8'h00;
            rd_rdy <= 1'b0;
        end else if (byte_ok) begin
            dout   <= rx_shift;
            rd_rdy <= 1'b1;
        end else if (rd_en && rd_rdy) begin
            rd_rdy <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart.sv
// tb/tb_uart.sv - scoreboard bench for uart: loopback pair plus directly driven rx
module tb_uart;

    localparam int N = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en1 = 1'b0, wr_en2 = 1'b0, rd_en1 = 1'b0, rd_en2 = 1'b0;
    logic [7:0] din1 = 8'h00, din2 = 8'h00;
    logic       wr_rdy1, wr_rdy2, rd_rdy1, rd_rdy2, tx1, tx2;
    logic [7:0] dout1, dout2;
    logic       loop_sel = 1'b1;
    logic       rx_drv = 1'b1;
    logic       rx2;

    int         total = 0;
    int         bad = 0;
    logic [7:0] sb[$];

    assign rx2 = loop_sel ? tx1 : rx_drv;

    always #5 clk = ~clk;

    uart #(.CLKS_PER_BIT(N)) u1 (
        .clk(clk), .rst(rst), .wr_en(wr_en1), .din(din1), .wr_rdy(wr_rdy1),
        .rd_en(rd_en1), .rd_rdy(rd_rdy1), .dout(dout1), .rx(tx2), .tx(tx1)
    );

    uart #(.CLKS_PER_BIT(N)) u2 (
        .clk(clk), .rst(rst), .wr_en(wr_en2), .din(din2), .wr_rdy(wr_rdy2),
        .rd_en(rd_en2), .rd_rdy(rd_rdy2), .dout(dout2), .rx(rx2), .tx(tx2)
    );

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_tx1_idle();
        int i = 0;
        while (!wr_rdy1 && i < 1000) begin
            @(negedge clk);
            i++;
        end
        chk1("tx1_idle", wr_rdy1, 1'b1);
    endtask

    task automatic drain(input int limit);
        int i = 0;
        while (sb.size() != 0 && i < limit) begin
            @(negedge clk);
            i++;
        end
        chki("sb_drain", sb.size(), 0);
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_drv = f[i];
            repeat (N) @(negedge clk);
        end
        rx_drv = 1'b1;
    endtask

    initial begin : monitor
        logic       prev_rdy;
        logic [7:0] prev_dout;
        logic [7:0] exp_b;
        prev_rdy  = 1'b0;
        prev_dout = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst && rd_rdy2 && (!prev_rdy || dout2 != prev_dout)) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rx2_unexpected: got %02h expected no byte", dout2);
                end else begin
                    exp_b = sb.pop_front();
                    chk8("rx2_byte", dout2, exp_b);
                end
            end
            prev_rdy  = rd_rdy2;
            prev_dout = dout2;
        end
    end

    initial begin : stim
        int         lat, low, j, gap;
        logic       seen_hi;
        int         berr[10];
        logic [9:0] f;

        repeat (3) @(negedge clk);
        chk1("reset_tx", tx1, 1'b1);
        chk1("reset_wr_rdy", wr_rdy1, 1'b1);
        chk1("reset_rd_rdy", rd_rdy1, 1'b0);
        chk8("reset_dout", dout1, 8'h00);
        rst = 1'b0;
        wait_cycles(5);

        // Full-duplex loopback: E8 to u2 while u2 sends 3A back to u1
        rd_en2 = 1'b1;
        sb.push_back(8'hE8);
        din1 = 8'hE8; wr_en1 = 1'b1;
        din2 = 8'h3A; wr_en2 = 1'b1;
        @(negedge clk);
        wr_en1 = 1'b0; wr_en2 = 1'b0;
        lat = 0;
        while (!rd_rdy2 && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        chk1("loop_latency_window", (lat >= 153 && lat <= 157), 1'b1);
        chk1("loop_before_wr_rdy", wr_rdy1, 1'b0);
        wait_cycles(3);
        chk1("loop_popped", rd_rdy2, 1'b0);
        chk8("loop_dout_held", dout2, 8'hE8);
        wait_tx1_idle();
        wait_cycles(5);
        chk1("duplex_rd_rdy1", rd_rdy1, 1'b1);
        chk8("duplex_dout1", dout1, 8'h3A);

        // Waveform of 0x55
        sb.push_back(8'h55);
        f = {1'b1, 8'h55, 1'b0};
        for (int i = 0; i < 10; i++) berr[i] = 0;
        @(negedge clk);
        din1 = 8'h55; wr_en1 = 1'b1;
        @(negedge clk);
        wr_en1 = 1'b0;
        j = 0;
        low = 0;
        while (!wr_rdy1 && j < 200) begin
            if (j < 10 * N && tx1 !== f[j / N]) berr[j / N]++;
            low++;
            j++;
            @(negedge clk);
        end
        for (int i = 0; i < 10; i++) chki($sformatf("wave_bit%0d_bad_cycles", i), berr[i], 0);
        chki("wave_wr_rdy_low", low, 10 * N);
        drain(400);

        // Back-to-back with wr_en held and din changed mid-frame
        sb.push_back(8'h01);
        sb.push_back(8'hFF);
        wait_tx1_idle();
        din1 = 8'h01; wr_en1 = 1'b1;
        @(negedge clk);
        gap = 0;
        seen_hi = 1'b0;
        while (gap < 400) begin
            @(negedge clk);
            gap++;
            if (gap == 40) din1 = 8'hFF;
            if (wr_rdy1) seen_hi = 1'b1;
            else if (seen_hi) break;
        end
        wr_en1 = 1'b0;
        chki("b2b_accept_gap", gap, 10 * N + 1);
        drain(600);

        // Framing error, glitch, then a valid frame on the driven line
        wait_tx1_idle();
        loop_sel = 1'b0;
        wait_cycles(4);
        rx_frame(8'hA5, 1'b0);
        wait_cycles(3 * N);
        chk8("framing_dout_held", dout2, 8'hFF);
        rx_drv = 1'b0;
        wait_cycles(N / 4);
        rx_drv = 1'b1;
        wait_cycles(3 * N);
        chk8("glitch_dout_held", dout2, 8'hFF);
        sb.push_back(8'h3C);
        rx_frame(8'h3C, 1'b1);
        wait_cycles(N);
        chk8("after_errors_dout", dout2, 8'h3C);
        drain(50);

        // Overrun
        rd_en2 = 1'b0;
        sb.push_back(8'h11);
        sb.push_back(8'h22);
        rx_frame(8'h11, 1'b1);
        rx_frame(8'h22, 1'b1);
        wait_cycles(N);
        chk1("overrun_rd_rdy", rd_rdy2, 1'b1);
        chk8("overrun_dout", dout2, 8'h22);
        rd_en2 = 1'b1;
        @(negedge clk);
        rd_en2 = 1'b0;
        chk1("overrun_pop", rd_rdy2, 1'b0);
        chk8("overrun_pop_dout", dout2, 8'h22);
        drain(10);

        // Asynchronous reset mid-frame, while tx1 is driving a 0 bit
        loop_sel = 1'b1;
        din1 = 8'h0F; wr_en1 = 1'b1;
        @(negedge clk);
        wr_en1 = 1'b0;
        wait_cycles(100);
        chk1("pre_reset_tx_low", tx1, 1'b0);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk1("async_reset_tx", tx1, 1'b1);
        chk1("async_reset_wr_rdy", wr_rdy1, 1'b1);
        chk1("async_reset_rd_rdy1", rd_rdy1, 1'b0);
        chk8("async_reset_dout1", dout1, 8'h00);
        chk8("async_reset_dout2", dout2, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        wait_cycles(12 * N);
        chk1("no_partial_after_reset", rd_rdy2, 1'b0);
        chki("sb_final_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
